// File: rtl/memory_stream_reader.sv
// memory_stream_reader
// Walks a contiguous, wrap-around address range of a dual-port memory through
// its combinational read port and presents the words as a valid/ready stream.
// A start command latches the base address and word count. Full throughput is
// one word per cycle, and the output holds steady while the consumer stalls.

module memory_stream_reader #(
    parameter int DEPTH    = 16,
    parameter int BIT_SIZE = 16,
    localparam int AW      = $clog2(DEPTH),
    localparam int LW      = AW + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [AW-1:0]       base_addr,
    input  logic [LW-1:0]       length,
    output logic                busy,
    output logic                done,
    output logic [AW-1:0]       mem_read_addr,
    input  logic [BIT_SIZE-1:0] mem_data,
    output logic [BIT_SIZE-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic [AW-1:0]       r_addr;
    logic [LW-1:0]       r_remaining;
    logic [BIT_SIZE-1:0] r_outData;
    logic                r_outValid;
    logic                r_outLast;
    logic                r_done;

    logic                w_accept;
    logic                w_zeroStart;
    logic                w_load;
    logic                w_drain;
    logic [AW-1:0]       w_addrNext;

    // State register; reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: decode start commands in IDLE.
    // In STREAM, fetch a word whenever the output slot is free and words remain.
    // Return to IDLE once the final word has been taken by the consumer.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_zeroStart = 1'b0;
        w_load      = 1'b0;
        w_drain     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        w_accept    = 1'b1;
                        w_nextState = STREAM;
                    end else begin
                        w_zeroStart = 1'b1;
                    end
                end
            end
            STREAM: begin
                if ((r_remaining != '0) && (!r_outValid || out_ready)) begin
                    w_load = 1'b1;
                end
                if ((r_remaining == '0) && r_outValid && out_ready) begin
                    w_drain     = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Address increment wraps at the last word so non-power-of-two depths work.
    always_comb begin
        w_addrNext = (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + AW'(1);
    end

    // Datapath: latch burst parameters on start, load the output register
    // from the memory read port, and clear the stream once the burst drains.
    // A zero-length start or a drain produces the single-cycle done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_outData   <= '0;
            r_outValid  <= 1'b0;
            r_outLast   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_zeroStart | w_drain;
            if (w_accept) begin
                r_addr      <= base_addr;
                r_remaining <= length;
            end
            if (w_load) begin
                r_outData   <= mem_data;
                r_outValid  <= 1'b1;
                r_outLast   <= (r_remaining == LW'(1));
                r_remaining <= r_remaining - LW'(1);
                r_addr      <= w_addrNext;
            end
            if (w_drain) begin
                r_outValid <= 1'b0;
                r_outLast  <= 1'b0;
            end
        end
    end

    assign busy          = (r_state != IDLE);
    assign done          = r_done;
    assign mem_read_addr = r_addr;
    assign out_data      = r_outData;
    assign out_valid     = r_outValid;
    assign out_last      = r_outLast;

endmodule

// File: tb/tb_memory_stream_reader.sv
// Testbench for memory_stream_reader.
// Stimulus pushes each expected beat, computed from a memory array, into a
// queue. A negedge monitor pops and compares on every handshake, checks
// hold-steady behaviour during stalls, and checks done pulses.

module tb_memory_stream_reader;

    localparam int DEPTH    = 16;
    localparam int BIT_SIZE = 16;
    localparam int AW       = $clog2(DEPTH);
    localparam int LW       = AW + 1;

    typedef struct {
        logic [BIT_SIZE-1:0] data;
        logic                last;
    } expItem_t;

    logic                clk;
    logic                rst;
    logic                start;
    logic [AW-1:0]       base_addr;
    logic [LW-1:0]       length;
    logic                busy;
    logic                done;
    logic [AW-1:0]       mem_read_addr;
    logic [BIT_SIZE-1:0] mem_data;
    logic [BIT_SIZE-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;

    logic [BIT_SIZE-1:0] mem [DEPTH];

    expItem_t            expQ[$];
    expItem_t            monItem;
    int                  readyPattern[$];
    int                  pendingDone;
    int                  beatCount;
    int                  assertCount;
    int                  failCount;
    bit                  randMode;
    bit                  prevStall;
    bit                  prevDone;
    logic [BIT_SIZE-1:0] prevData;
    logic                prevLast;

    memory_stream_reader #(
        .DEPTH    (DEPTH),
        .BIT_SIZE (BIT_SIZE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .length        (length),
        .busy          (busy),
        .done          (done),
        .mem_read_addr (mem_read_addr),
        .mem_data      (mem_data),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last)
    );

    // Combinational memory read port.
    assign mem_data = mem[mem_read_addr];

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic failNow(input string name);
        assertCount++;
        failCount++;
        $display("[TB] FAIL %s: event not expected at %0t", name, $time);
    endtask

    // Issue one start command and record the beats the reference model predicts.
    task automatic applyStimulus(input int base, input int len);
        expItem_t item;
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = AW'(base);
        length    = LW'(len);
        for (int i = 0; i < len; i++) begin
            item.data = mem[(base + i) % DEPTH];
            item.last = (i == len - 1);
            expQ.push_back(item);
        end
        pendingDone++;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Run cycles, driving out_ready, until everything expected has been seen.
    task automatic waitIdle(input int maxCycles);
        int n;
        n = 0;
        while (!(expQ.size() == 0 && pendingDone == 0 && busy == 1'b0)) begin
            if (n >= maxCycles) begin
                failNow("waitIdleTimeout");
                expQ.delete();
                pendingDone = 0;
                break;
            end
            @(posedge clk);
            #1;
            if (readyPattern.size() > 0) out_ready = readyPattern.pop_front() != 0;
            else if (randMode)           out_ready = $urandom_range(0, 1) != 0;
            else                         out_ready = 1'b1;
            n++;
        end
    endtask

    // Scoreboard monitor: compare on handshakes, verify stalls hold, track done.
    always @(negedge clk) begin
        if (rst) begin
            prevStall = 1'b0;
            prevDone  = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("holdValid", 32'(out_valid), 32'd1);
                checkOutput("holdData", 32'(out_data), 32'(prevData));
                checkOutput("holdLast", 32'(out_last), 32'(prevLast));
            end
            if (out_valid) begin
                checkOutput("validBusy", 32'(busy), 32'd1);
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    failNow("unexpectedBeat");
                end else begin
                    monItem = expQ.pop_front();
                    checkOutput("beatData", 32'(out_data), 32'(monItem.data));
                    checkOutput("beatLast", 32'(out_last), 32'(monItem.last));
                    beatCount++;
                end
            end
            if (done) begin
                checkOutput("doneBusy", 32'(busy), 32'd0);
                if (prevDone)              failNow("donePulseWidth");
                else if (pendingDone == 0) failNow("unexpectedDone");
                else begin
                    pendingDone--;
                    checkOutput("doneBeatsLeft", 32'(expQ.size()), 32'd0);
                end
            end
            prevDone  = done;
            prevStall = out_valid && !out_ready;
            prevData  = out_data;
            prevLast  = out_last;
        end
    end

    // Directed scenarios followed by a randomized phase.
    initial begin
        int startBeats;
        bit seen;
        assertCount = 0;
        failCount   = 0;
        pendingDone = 0;
        beatCount   = 0;
        randMode    = 1'b0;
        prevStall   = 1'b0;
        prevDone    = 1'b0;
        prevData    = '0;
        prevLast    = 1'b0;
        rst         = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        length      = '0;
        out_ready   = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = BIT_SIZE'(16'h100 + i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetValid", 32'(out_valid), 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);
        checkOutput("resetAddr", 32'(mem_read_addr), 32'd0);
        checkOutput("resetData", 32'(out_data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] basic burst base=3 length=4");
        applyStimulus(3, 4);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checkOutput("latBusy", 32'(busy), 32'd1);
                checkOutput("latValid0", 32'(out_valid), 32'd0);
            end
            if (k == 1) begin
                checkOutput("latValid1", 32'(out_valid), 32'd1);
                checkOutput("firstData", 32'(out_data), 32'h103);
            end
            if (k == 4) checkOutput("lastFlag", 32'(out_last), 32'd1);
            if (k < 5)  checkOutput("doneEarly", 32'(done), 32'd0);
            if (k == 5) begin
                checkOutput("doneTiming", 32'(done), 32'd1);
                checkOutput("busyAtDone", 32'(busy), 32'd0);
            end
        end
        waitIdle(100);

        $display("[TB] wrap burst base=14 length=5");
        applyStimulus(14, 5);
        waitIdle(100);
        checkOutput("wrapAddrEnd", 32'(mem_read_addr), 32'((14 + 5) % DEPTH));

        $display("[TB] backpressure burst base=0 length=3");
        readyPattern = '{1, 0, 0, 1, 0, 1};
        applyStimulus(0, 3);
        waitIdle(100);

        $display("[TB] zero-length start");
        applyStimulus(7, 0);
        @(negedge clk);
        checkOutput("zeroDone", 32'(done), 32'd1);
        checkOutput("zeroBusy", 32'(busy), 32'd0);
        checkOutput("zeroValid", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("zeroDoneOnce", 32'(done), 32'd0);
        checkOutput("zeroBusyLater", 32'(busy), 32'd0);
        waitIdle(20);

        $display("[TB] full-depth burst base=5 length=16");
        applyStimulus(5, 16);
        waitIdle(200);
        checkOutput("fullAddrEnd", 32'(mem_read_addr), 32'((5 + 16) % DEPTH));

        $display("[TB] start pulsed mid-burst");
        applyStimulus(2, 6);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = AW'(9);
        length    = LW'(3);
        @(posedge clk);
        #1;
        start = 1'b0;
        waitIdle(100);

        $display("[TB] reset on third beat of length-8 burst");
        startBeats = beatCount;
        applyStimulus(1, 8);
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (beatCount >= startBeats + 2) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) failNow("resetWaitTimeout");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expQ.delete();
        pendingDone = 0;
        @(negedge clk);
        checkOutput("midResetValid", 32'(out_valid), 32'd0);
        checkOutput("midResetLast", 32'(out_last), 32'd0);
        checkOutput("midResetData", 32'(out_data), 32'd0);
        checkOutput("midResetDone", 32'(done), 32'd0);
        checkOutput("midResetBusy", 32'(busy), 32'd0);
        checkOutput("midResetAddr", 32'(mem_read_addr), 32'd0);
        @(negedge clk);
        checkOutput("noDoneAfterReset", 32'(done), 32'd0);
        applyStimulus(4, 3);
        waitIdle(100);

        $display("[TB] randomized bursts");
        randMode = 1'b1;
        for (int b = 0; b < 25; b++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = BIT_SIZE'($urandom);
            applyStimulus(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)));
            waitIdle(400);
        end
        randMode  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
